// File: rtl/seg_display_arbiter_pkg.sv
// seg_pkg: shared types and constants for the seven-segment display arbiter.
//   owner_t   - display ownership (IDLE / CPU / DBG), also the owner output encoding
//   SEG_BLANK - all-off cathode pattern (active low, dp included)
//   HEX_TABLE - active-low {g,f,e,d,c,b,a} pattern per hex nibble
//   msd_index - position of the most significant nonzero nibble (0 for value 0)
package seg_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Element n is the pattern for nibble n; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [2:0] msd_index(input logic [31:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[4*k +: 4] != 4'h0) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: write ports of the two display writers.
//   cpu_wr_valid/ready/data/mask - high-priority CPU MMIO writer
//   dbg_wr_valid/ready/data      - low-priority debug monitor (mask implied 8'hFF)
//   master modport: writer side; slave modport: arbiter side.
interface seg_display_arbiter_if;

    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [31:0] cpu_wr_data;
    logic [7:0]  cpu_wr_mask;
    logic        dbg_wr_valid;
    logic        dbg_wr_ready;
    logic [31:0] dbg_wr_data;

    modport master (
        output cpu_wr_valid, cpu_wr_data, cpu_wr_mask, dbg_wr_valid, dbg_wr_data,
        input  cpu_wr_ready, dbg_wr_ready
    );

    modport slave (
        input  cpu_wr_valid, cpu_wr_data, cpu_wr_mask, dbg_wr_valid, dbg_wr_data,
        output cpu_wr_ready, dbg_wr_ready
    );

endinterface

// File: rtl/seg_display_arbiter_hex_decode.sv
// seg_hex_decode: combinational hex nibble to seven-segment pattern.
//   i_nibble - hex digit value
//   o_seg    - active-low {g,f,e,d,c,b,a}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_TABLE[i_nibble];

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares an 8-digit seven-segment display between a CPU
// writer (high priority) and a debug writer (low priority), double-buffers the
// value so it only changes at frame boundaries, and scans the digits.
//   clk, rst_n - system clock, asynchronous active-low reset
//   wr         - writer handshakes (seg_display_arbiter_if.slave)
//   an         - anode select, active low, at most one digit on
//   seg        - {dp,g,f,e,d,c,b,a}, active low, dp always off
//   owner      - 0 IDLE, 1 CPU, 2 DBG
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero nibble (digit 0 always shown).
//
// Ownership states:
//   state    | meaning
//   OWN_IDLE | nobody holds the display, both writers may be accepted
//   OWN_CPU  | CPU holds it; debug writes stall until the hold expires
//   OWN_DBG  | debug holds it; CPU may still preempt between debug transfers
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned HOLD_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_arbiter_if.slave  wr,
    output logic [7:0]            an,
    output logic [7:0]            seg,
    output logic [1:0]            owner
);

    localparam int unsigned    DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]     HOLD_INIT = 8'(HOLD_FRAMES);

    owner_t           r_owner;
    logic [7:0]       r_hold;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [31:0]      r_shadow_data;
    logic [7:0]       r_shadow_mask;
    logic             r_pending;
    logic [31:0]      r_live_data;
    logic [7:0]       r_live_mask;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;

    logic             w_cpu_ready;
    logic             w_dbg_ready;
    logic             w_cpu_acc;
    logic             w_dbg_acc;
    logic             w_acc;
    logic             w_tick;
    logic             w_frame;
    logic [3:0]       w_nibble;
    logic [6:0]       w_hex;
    logic             w_lz_blank;
    logic             w_digit_on;

    // CPU only waits while debug owns the display and is mid-transfer.
    assign w_cpu_ready = (r_owner != OWN_DBG) || !wr.dbg_wr_valid;
    assign w_dbg_ready = (r_owner != OWN_CPU) && !wr.cpu_wr_valid;
    assign w_cpu_acc   = wr.cpu_wr_valid && w_cpu_ready;
    assign w_dbg_acc   = wr.dbg_wr_valid && w_dbg_ready;
    assign w_acc       = w_cpu_acc || w_dbg_acc;

    assign wr.cpu_wr_ready = w_cpu_ready;
    assign wr.dbg_wr_ready = w_dbg_ready;

    assign w_tick  = (r_div == DIV_LAST);
    assign w_frame = w_tick && (r_idx == 3'd7);

    // Scan divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= 3'd0;
        end else if (w_tick) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Ownership FSM; an accept reloads the hold even on a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IDLE;
            r_hold  <= 8'd0;
        end else if (w_cpu_acc) begin
            r_owner <= OWN_CPU;
            r_hold  <= HOLD_INIT;
        end else if (w_dbg_acc) begin
            r_owner <= OWN_DBG;
            r_hold  <= HOLD_INIT;
        end else if (w_frame && (r_owner != OWN_IDLE)) begin
            if (r_hold <= 8'd1) begin
                r_owner <= OWN_IDLE;
                r_hold  <= 8'd0;
            end else begin
                r_hold  <= r_hold - 8'd1;
            end
        end
    end

    // Shadow/live double buffer. A write landing on the boundary cycle sets
    // pending again, so it waits for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_data <= 32'h0;
            r_shadow_mask <= 8'hFF;
            r_pending     <= 1'b0;
            r_live_data   <= 32'h0;
            r_live_mask   <= 8'hFF;
        end else begin
            if (w_acc) begin
                r_shadow_data <= w_cpu_acc ? wr.cpu_wr_data : wr.dbg_wr_data;
                r_shadow_mask <= w_cpu_acc ? wr.cpu_wr_mask : 8'hFF;
            end
            if (w_frame && r_pending) begin
                r_live_data <= r_shadow_data;
                r_live_mask <= r_shadow_mask;
            end
            if (w_acc) begin
                r_pending <= 1'b1;
            end else if (w_frame) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_nibble = r_live_data[{r_idx, 2'b00} +: 4];

    seg_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign w_lz_blank = (r_idx > msd_index(r_live_data));
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_digit_on = r_live_mask[r_idx] && !w_lz_blank;

    // Pins follow the current index and live value one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 8'hFF;
            r_seg <= SEG_BLANK;
        end else if (w_digit_on) begin
            r_an  <= ~(8'h01 << r_idx);
            r_seg <= {1'b1, w_hex};
        end else begin
            r_an  <= 8'hFF;
            r_seg <= SEG_BLANK;
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign owner = r_owner;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with SCAN_DIV=4, HOLD_FRAMES=2
// (4-cycle digit slots, 32-cycle frames). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_seg_display_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] an;
    logic [7:0] seg;
    logic [1:0] owner;
    int         n_checks;
    int         n_errors;

    seg_display_arbiter_if wr_if ();

    seg_display_arbiter #(
        .SCAN_DIV    (4),
        .HOLD_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_if),
        .an    (an),
        .seg   (seg),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the first falling edge where digit 0 has just been lit.
    task automatic wait_frame_start(input string tag);
        int n;
        n = 0;
        while (an == 8'hFE && n < 200) begin @(negedge clk); n++; end
        while (an != 8'hFE && n < 400) begin @(negedge clk); n++; end
        check_val(tag, {24'h0, an}, 32'h0000_00FE);
    endtask

    // Called on a falling edge; returns one falling edge after the accept.
    task automatic cpu_write(input logic [31:0] d, input logic [7:0] m);
        int n;
        n = 0;
        wr_if.cpu_wr_valid = 1'b1;
        wr_if.cpu_wr_data  = d;
        wr_if.cpu_wr_mask  = m;
        #1;
        while (!wr_if.cpu_wr_ready && n < 200) begin @(negedge clk); #1; n++; end
        check_val("cpu_accept", {31'h0, wr_if.cpu_wr_ready}, 32'h1);
        @(negedge clk);
        wr_if.cpu_wr_valid = 1'b0;
    endtask

    task automatic check_slot(input string tag, input logic [7:0] exp_an, input logic [7:0] exp_seg);
        check_val({tag, "_an"}, {24'h0, an}, {24'h0, exp_an});
        check_val({tag, "_seg"}, {24'h0, seg}, {24'h0, exp_seg});
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        wr_if.cpu_wr_valid = 1'b0;
        wr_if.cpu_wr_data  = 32'h0;
        wr_if.cpu_wr_mask  = 8'h00;
        wr_if.dbg_wr_valid = 1'b0;
        wr_if.dbg_wr_data  = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check_slot("rst", 8'hFF, 8'hFF);
        check_val("rst_owner", {30'h0, owner}, 32'd0);
        check_val("rst_cpu_rdy", {31'h0, wr_if.cpu_wr_ready}, 32'h1);
        check_val("rst_dbg_rdy", {31'h0, wr_if.dbg_wr_ready}, 32'h1);
        rst_n = 1'b1;

        // Idle display shows zeros
        wait_frame_start("sync_idle");
        check_slot("idle_d0", 8'hFE, 8'hC0);
        repeat (28) @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_slot("idle_d7", 8'hFF, 8'hFF);
`else
        check_slot("idle_d7", 8'h7F, 8'hC0);
`endif

        // CPU write mid-frame: old value holds until the boundary
        wait_frame_start("sync_cpu");
        repeat (8) @(negedge clk);
        cpu_write(32'h1234_ABCD, 8'hFF);
        check_val("cpu_owner", {30'h0, owner}, 32'd1);
        repeat (11) @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_slot("old_d5", 8'hFF, 8'hFF);
`else
        check_slot("old_d5", 8'hDF, 8'hC0);
`endif
        wait_frame_start("sync_new");
        check_slot("new_d0", 8'hFE, 8'hA1);
        check_val("hold_owner", {30'h0, owner}, 32'd1);
        repeat (28) @(negedge clk);
        check_slot("new_d7", 8'h7F, 8'hF9);
        wait_frame_start("sync_expire");
        check_val("expire_owner", {30'h0, owner}, 32'd0);
        check_val("expire_cpu_rdy", {31'h0, wr_if.cpu_wr_ready}, 32'h1);
        check_val("expire_dbg_rdy", {31'h0, wr_if.dbg_wr_ready}, 32'h1);

        // Simultaneous requests while idle: CPU wins, debug waits for idle
        wr_if.cpu_wr_valid = 1'b1;
        wr_if.cpu_wr_data  = 32'h1111_1111;
        wr_if.cpu_wr_mask  = 8'hFF;
        wr_if.dbg_wr_valid = 1'b1;
        wr_if.dbg_wr_data  = 32'h9876_FEDC;
        #1;
        check_val("both_cpu_rdy", {31'h0, wr_if.cpu_wr_ready}, 32'h1);
        check_val("both_dbg_rdy", {31'h0, wr_if.dbg_wr_ready}, 32'h0);
        @(negedge clk);
        wr_if.cpu_wr_valid = 1'b0;
        #1;
        check_val("both_owner", {30'h0, owner}, 32'd1);
        check_val("stall_dbg_rdy", {31'h0, wr_if.dbg_wr_ready}, 32'h0);
        n = 0;
        while (!wr_if.dbg_wr_ready && n < 200) begin @(negedge clk); #1; n++; end
        check_val("dbg_accept", {31'h0, wr_if.dbg_wr_ready}, 32'h1);
        @(negedge clk);
        wr_if.dbg_wr_valid = 1'b0;
        check_val("dbg_owner", {30'h0, owner}, 32'd2);
        wait_frame_start("sync_dbg");
        check_slot("dbg_d0", 8'hFE, 8'hC6);
        repeat (28) @(negedge clk);
        check_slot("dbg_d7", 8'h7F, 8'h90);

        // CPU preempts debug owner with zero value, low nibbles only
        cpu_write(32'h0, 8'h0F);
        check_val("preempt_owner", {30'h0, owner}, 32'd1);
        wait_frame_start("sync_mask");
        check_slot("mask_d0", 8'hFE, 8'hC0);
        repeat (4) @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_slot("mask_d1", 8'hFF, 8'hFF);
`else
        check_slot("mask_d1", 8'hFD, 8'hC0);
`endif
        repeat (8) @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_slot("mask_d3", 8'hFF, 8'hFF);
`else
        check_slot("mask_d3", 8'hF7, 8'hC0);
`endif
        repeat (4) @(negedge clk);
        check_slot("mask_d4", 8'hFF, 8'hFF);
        repeat (12) @(negedge clk);
        check_slot("mask_d7", 8'hFF, 8'hFF);

        // Three writes in one frame: last one wins
        wait_frame_start("sync_multi");
        cpu_write(32'h1, 8'hFF);
        cpu_write(32'h2, 8'hFF);
        cpu_write(32'h3, 8'hFF);
        wait_frame_start("sync_last");
        check_slot("last_d0", 8'hFE, 8'hB0);
        repeat (4) @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_slot("last_d1", 8'hFF, 8'hFF);
`else
        check_slot("last_d1", 8'hFD, 8'hC0);
`endif

        // Write accepted on the boundary cycle waits one more frame
        repeat (26) @(negedge clk);
        cpu_write(32'h6, 8'hFF);
        wait_frame_start("sync_bnd1");
        check_slot("bnd_hold_d0", 8'hFE, 8'hB0);
        wait_frame_start("sync_bnd2");
        check_slot("bnd_new_d0", 8'hFE, 8'h82);

        // Reset mid-frame drops the pending shadow
        repeat (6) @(negedge clk);
        cpu_write(32'h7777_7777, 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_slot("midrst", 8'hFF, 8'hFF);
        check_val("midrst_owner", {30'h0, owner}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame_start("sync_rst1");
        check_slot("rst1_d0", 8'hFE, 8'hC0);
        wait_frame_start("sync_rst2");
        check_slot("rst2_d0", 8'hFE, 8'hC0);
        check_val("rst2_owner", {30'h0, owner}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Owns the 8-digit seven-segment display and shares it between two writers: the CPU MMIO path (port cpu_*, high priority) and a debug monitor (port dbg_*, low priority).
- Arbitrates writes through a valid/ready handshake with an ownership hold.
- Double-buffers the 32-bit hex value and commits it tear-free at frame boundaries.
- Generates the digit-scan timing, hex-to-segment decode and per-digit blanking that drive the board anode/cathode pins.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot; legal range 2..2^20.
- HOLD_FRAMES, 16: full 8-digit frames an owner keeps the display after its last accepted write; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  CPU write accepted when valid && ready
- cpu_wr_data  in  32  8 hex nibbles; nibble k goes to digit k
- cpu_wr_mask  in  8  per-digit enable; 0 blanks the digit
- dbg_wr_valid  in  1  debug write request
- dbg_wr_ready  out  1  debug write accepted when valid && ready
- dbg_wr_data  in  32  debug value; mask is forced to 8'hFF
- an  out  8  anode select, active low, one-hot-zero
- seg  out  8  {dp,g,f,e,d,c,b,a}, active low; dp is always 1
- owner  out  2  0=IDLE, 1=CPU, 2=DBG

Behaviour:
Reset (asynchronous on rst_n low):
- an=8'hFF, seg=8'hFF, owner=IDLE.
- Shadow and live data=0, both masks=8'hFF.
- Digit index=0; divider, hold counter and pending flag cleared.
- Reset mid-frame or mid-handshake drops any pending shadow value.

Ownership FSM (IDLE, CPU, DBG):
- cpu_wr_ready = (owner != DBG) || (owner==DBG && no dbg_wr_valid this cycle). CPU preempts DBG between debug transfers.
- dbg_wr_ready = (owner != CPU) && !cpu_wr_valid.
- Both valid in the same cycle: CPU is accepted and dbg stalls.
- On an accept, owner becomes the accepted source next cycle and the hold counter reloads to HOLD_FRAMES.
- Each frame boundary without an accept decrements the hold counter. At 0, owner returns to IDLE and the display keeps the last value.
- An accept on the same cycle as a frame boundary reloads the counter; the reload wins over the decrement.

Buffering:
- An accepted write loads the shadow data and mask on the next edge and sets pending.
- Back-to-back accepts within one frame overwrite the shadow (last write wins).
- On each frame boundary, if pending is set: live <= shadow and pending is cleared.
- A write accepted on the boundary cycle itself is committed at the following boundary.

Scan timing:
- The divider counts 0..SCAN_DIV-1. tick = (count==SCAN_DIV-1).
- On each tick the digit index advances 0..7 and wraps. Frame boundary = tick with index==7.
- an and seg are registered and update one cycle after the tick for the new index.
- Displayed digit k: an = ~(1<<k); seg = {1'b1, HEX[live_data[4k+3:4k]]}.
- If live_mask[k]==0: an=8'hFF and seg=8'hFF for that slot; the slot time is preserved.
- Max latency from accept to visible: 8*SCAN_DIV+2 cycles.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero nibble of live data are blanked as if their mask bit were 0. Digit 0 is never blanked by this rule. Value 0 shows a single "0".
- Undefined: all masked-in digits show their nibble, including leading zeros.

Decomposition:
- Package seg_pkg:
  - owner_t enum {OWN_IDLE=0, OWN_CPU=1, OWN_DBG=2}
  - SEG_BLANK=8'hFF
  - 16-entry active-low HEX table (g..a): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Sub-module seg_hex_decode (nibble in, 7-bit pattern out) using the package table.
- Arbiter, buffers and scan logic stay in the top module.

Test Plan (SCAN_DIV=4, HOLD_FRAMES=2):
- Reset release with no writes -> an/seg cycle through slots showing "0" on each digit; owner=0; both ready=1.
- CPU writes 32'h1234ABCD with mask FF mid-frame -> old value held until the boundary. Next frame: digit0 seg=8'hA1 (d), digit7 seg=8'hF9 (1). owner=1 until 2 idle frames elapse, then 0.
- CPU and dbg valid in the same cycle while IDLE -> cpu accepted, dbg_wr_ready=0, owner=1. Dbg is accepted only after owner returns to 0; it shows the dbg value, with owner=2.
- Dbg owner, CPU write 32'h0 with mask 8'h0F -> CPU preempts, owner=1. Digits 4..7 have an=FF. With SEG_LEADING_ZERO_BLANK_EN, digits 1..3 also blank and digit0 shows 8'hC0.
- Three CPU writes in one frame (1, 2, 3) -> only 32'h3 is committed. Assert rst_n low mid-frame -> an=seg=FF immediately and the shadow is discarded.
